// File: rtl/term_sm_pkg.sv
// Shared definitions for the loopback switch matrix: per-channel routing
// modes, configuration loader states and the word-count helper.
package term_sm_pkg;

  // Per-channel routing mode held in the active configuration register.
  typedef enum logic [1:0] {
    MODE_MIRROR_COMB = 2'b00,
    MODE_MIRROR_REG  = 2'b01,
    MODE_STRAIGHT    = 2'b10,
    MODE_TIE_LOW     = 2'b11
  } mode_e;

  // Configuration loader states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_FULL  = 2'b10,
    ST_APPLY = 2'b11
  } state_e;

  // Number of configuration words needed to cover 2 mode bits per channel.
  function automatic int nw_words(input int nch, input int cfg_w);
    return (2 * nch + cfg_w - 1) / cfg_w;
  endfunction

endpackage

// File: rtl/term_cfg_loader.sv
// Configuration loader: collects a shadow image word by word, waits for a
// commit, then copies the shadow into the active mode register.
module term_cfg_loader
  import term_sm_pkg::*;
#(
  parameter int NCH   = 52,
  parameter int CFG_W = 8
) (
  input  logic               UserCLK,
  input  logic               resetn,
  input  logic               cfg_valid,
  input  logic [CFG_W-1:0]   cfg_data,
  input  logic               cfg_commit,
  output logic               cfg_ready,
  output logic               cfg_loaded,
  output logic               cfg_done,
  output logic [2*NCH-1:0]   o_active
);

  localparam int NW    = nw_words(NCH, CFG_W);
  localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;

  state_e             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [2*NCH-1:0]   r_shadow;
  logic [2*NCH-1:0]   r_active;
  logic               r_ready;
  logic               r_loaded;
  logic               r_done;

  // Loader FSM with word counter, shadow/active registers and registered handshake outputs.
  always_ff @(posedge UserCLK or negedge resetn) begin
    // NOTE: shadow and active images are ordinary flops, not a RAM, so they
    // are cleared by reset; a mid-load reset must leave no stale partial image.
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_shadow <= '0;
      r_active <= '0;
      r_ready  <= 1'b1;
      r_loaded <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of the state, counter and shadow.
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_LOAD: begin
          if (cfg_valid) begin
            // Word k lands on shadow bits [k*CFG_W +: CFG_W]; bits past 2*NCH have no home.
            for (int b = 0; b < 2 * NCH; b++) begin
              if (r_count == CNT_W'(b / CFG_W)) r_shadow[b] <= cfg_data[b % CFG_W];
            end
            if (r_count == CNT_W'(NW - 1)) begin
              r_state  <= ST_FULL;
              r_count  <= '0;
              r_ready  <= 1'b0;
              r_loaded <= 1'b1;
            end else begin
              r_state <= ST_LOAD;
              r_count <= r_count + CNT_W'(1);
            end
          end
        end
        ST_FULL: begin
          if (cfg_commit) begin
            r_state  <= ST_APPLY;
            r_loaded <= 1'b0;
          end
        end
        ST_APPLY: begin
          r_active <= r_shadow;
          r_state  <= ST_IDLE;
          r_ready  <= 1'b1;
          r_done   <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready  = r_ready;
  assign cfg_loaded = r_loaded;
  assign cfg_done   = r_done;
  assign o_active   = r_active;

endmodule

// File: rtl/term_loopback_switch_matrix.sv
// Terminal loopback switch matrix: routes S_END to N_BEG per channel as
// mirrored, mirrored-and-registered, straight, or tied low.
module term_loopback_switch_matrix
  import term_sm_pkg::*;
#(
  parameter int NCH   = 52,
  parameter int CFG_W = 8
) (
  input  logic               UserCLK,
  input  logic               resetn,
  input  logic [NCH-1:0]     S_END,
  output logic [NCH-1:0]     N_BEG,
  input  logic               cfg_valid,
  input  logic [CFG_W-1:0]   cfg_data,
  output logic               cfg_ready,
  input  logic               cfg_commit,
  output logic               cfg_loaded,
  output logic               cfg_done
);

  logic [2*NCH-1:0] w_active;
  logic [NCH-1:0]   r_pipe;

  term_cfg_loader #(
    .NCH   (NCH),
    .CFG_W (CFG_W)
  ) u_loader (
    .UserCLK    (UserCLK),
    .resetn     (resetn),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .cfg_ready  (cfg_ready),
    .cfg_loaded (cfg_loaded),
    .cfg_done   (cfg_done),
    .o_active   (w_active)
  );

  // Pipeline flops sample the mirrored input every cycle, whatever the mode.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      r_pipe <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) r_pipe[i] <= S_END[NCH-1-i];
    end
  end

  // Per-channel output select driven by the active mode.
  always_comb begin
    // NOTE: default every output bit first so no path through the case
    // leaves N_BEG unassigned and infers a latch.
    N_BEG = '0;
    for (int i = 0; i < NCH; i++) begin
      case (mode_e'(w_active[2*i +: 2]))
        MODE_MIRROR_COMB: N_BEG[i] = S_END[NCH-1-i];
        MODE_MIRROR_REG:  N_BEG[i] = r_pipe[i];
        MODE_STRAIGHT:    N_BEG[i] = S_END[i];
        default:          N_BEG[i] = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_term_loopback_switch_matrix.sv
// Self-checking bench for term_loopback_switch_matrix: directed table,
// hand-written configuration sequences and a randomized run against a
// channel-level reference model.
module tb_term_loopback_switch_matrix;

  localparam int NCH   = 52;
  localparam int CFG_W = 8;
  localparam int NW    = 13;

  logic             UserCLK = 1'b0;
  logic             resetn;
  logic [NCH-1:0]   S_END;
  logic [NCH-1:0]   N_BEG;
  logic             cfg_valid;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_ready;
  logic             cfg_commit;
  logic             cfg_loaded;
  logic             cfg_done;

  always #5 UserCLK = ~UserCLK;

  term_loopback_switch_matrix #(
    .NCH   (NCH),
    .CFG_W (CFG_W)
  ) dut (
    .UserCLK    (UserCLK),
    .resetn     (resetn),
    .S_END      (S_END),
    .N_BEG      (N_BEG),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .cfg_commit (cfg_commit),
    .cfg_loaded (cfg_loaded),
    .cfg_done   (cfg_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (channel/word level) ----------------
  int m_mode [NCH];
  bit m_shadow [2*NCH];
  bit m_prev [NCH];
  int m_words;
  bit m_full;
  bit m_apply;
  bit m_done;

  function automatic void m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = 0;
      m_prev[i] = 1'b0;
    end
    for (int b = 0; b < 2 * NCH; b++) m_shadow[b] = 1'b0;
    m_words = 0;
    m_full  = 1'b0;
    m_apply = 1'b0;
    m_done  = 1'b0;
  endfunction

  function automatic logic [NCH-1:0] m_nbeg(input logic [NCH-1:0] s);
    logic [NCH-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      case (m_mode[i])
        0:       r[i] = s[NCH-1-i];
        1:       r[i] = m_prev[i];
        2:       r[i] = s[i];
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  // Advance the model by one rising edge with the given inputs held.
  function automatic void m_edge(input bit v, input logic [CFG_W-1:0] d, input bit c,
                                 input logic [NCH-1:0] s);
    m_done = m_apply;
    if (m_apply) begin
      for (int i = 0; i < NCH; i++) m_mode[i] = 2 * int'(m_shadow[2*i+1]) + int'(m_shadow[2*i]);
      m_apply = 1'b0;
    end else if (m_full) begin
      if (c) begin
        m_full  = 1'b0;
        m_apply = 1'b1;
      end
    end else if (v) begin
      for (int j = 0; j < CFG_W; j++) begin
        if (m_words * CFG_W + j < 2 * NCH) m_shadow[m_words*CFG_W+j] = d[j];
      end
      m_words++;
      if (m_words == NW) begin
        m_words = 0;
        m_full  = 1'b1;
      end
    end
    for (int i = 0; i < NCH; i++) m_prev[i] = s[NCH-1-i];
  endfunction

  function automatic logic [NCH-1:0] rnd_s();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[NCH-1:0];
  endfunction

  // One clock cycle: drive, compare against the model, clock, advance the model.
  task automatic cycle(input bit v, input logic [CFG_W-1:0] d, input bit c,
                       input logic [NCH-1:0] s, input string tag);
    cfg_valid  = v;
    cfg_data   = d;
    cfg_commit = c;
    S_END      = s;
    #2;
    check({tag, " n_beg"},  64'(N_BEG),      64'(m_nbeg(s)));
    check({tag, " ready"},  64'(cfg_ready),  64'(!m_full && !m_apply));
    check({tag, " loaded"}, 64'(cfg_loaded), 64'(m_full));
    check({tag, " done"},   64'(cfg_done),   64'(m_done));
    @(posedge UserCLK);
    m_edge(v, d, c, s);
    #1;
  endtask

  task automatic load_words(input int n, input logic [CFG_W-1:0] d, input string tag);
    for (int k = 0; k < n; k++) cycle(1'b1, d, 1'b0, rnd_s(), tag);
  endtask

  // Commit from FULL, then spend the APPLY cycle; returns in the cfg_done cycle.
  task automatic commit_apply(input string tag);
    cycle(1'b0, '0, 1'b1, rnd_s(), tag);
    cycle(1'b0, '0, 1'b0, rnd_s(), tag);
  endtask

  typedef struct {
    logic [NCH-1:0] s;
    logic [NCH-1:0] exp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{52'h1,               52'h8_0000_0000_0000};
    tbl[1] = '{52'h8_0000_0000_0000, 52'h1};
    tbl[2] = '{52'hF,               52'hF_0000_0000_0000};
    tbl[3] = '{52'h3,               52'hC_0000_0000_0000};
    tbl[4] = '{52'h0,               52'h0};
    tbl[5] = '{52'hF_FFFF_FFFF_FFFF, 52'hF_FFFF_FFFF_FFFF};

    resetn     = 1'b0;
    cfg_valid  = 1'b0;
    cfg_data   = '0;
    cfg_commit = 1'b0;
    S_END      = '0;
    m_reset();
    repeat (2) @(posedge UserCLK);
    #1;
    resetn = 1'b1;

    // Reset state and index-reversed mirror, table driven.
    for (int i = 0; i < 6; i++) begin
      S_END = tbl[i].s;
      #2;
      check($sformatf("reset_mirror[%0d]", i), 64'(N_BEG), 64'(tbl[i].exp));
      check($sformatf("reset_ready[%0d]", i),  64'(cfg_ready),  64'(1));
      check($sformatf("reset_loaded[%0d]", i), 64'(cfg_loaded), 64'(0));
      check($sformatf("reset_done[%0d]", i),   64'(cfg_done),   64'(0));
      @(posedge UserCLK);
      m_edge(1'b0, '0, 1'b0, S_END);
      #1;
    end

    // All channels mirror-registered; done pulse and one-cycle latency.
    for (int k = 0; k < NW; k++) cycle(1'b1, 8'h55, 1'b0, '0, "load55");
    check("full_loaded", 64'(cfg_loaded), 64'(1));
    cycle(1'b0, '0, 1'b1, '0, "commit55");
    check("apply_no_done", 64'(cfg_done), 64'(0));
    cycle(1'b0, '0, 1'b0, '0, "apply55");
    check("done_pulse", 64'(cfg_done), 64'(1));
    check("done_ready", 64'(cfg_ready), 64'(1));
    cycle(1'b0, '0, 1'b0, '0, "post55");
    check("done_single", 64'(cfg_done), 64'(0));
    S_END = 52'h1;
    #1;
    check("reg_before_edge", 64'(N_BEG[51]), 64'(0));
    cycle(1'b0, '0, 1'b0, 52'h1, "step55");
    check("reg_after_edge", 64'(N_BEG[51]), 64'(1));

    // Straight mode: no change before commit, N_BEG==S_END after.
    load_words(NW, 8'hAA, "loadAA");
    commit_apply("commitAA");
    cycle(1'b0, '0, 1'b0, rnd_s(), "postAA");
    for (int k = 0; k < 3; k++) begin
      S_END = rnd_s();
      #1;
      check($sformatf("straight[%0d]", k), 64'(N_BEG), 64'(S_END));
    end

    // Commit mid-load ignored; full image blocks further words.
    load_words(5, 8'hFF, "partial");
    cycle(1'b0, '0, 1'b1, rnd_s(), "early_commit");
    cycle(1'b0, '0, 1'b0, rnd_s(), "early_commit2");
    check("early_no_done", 64'(cfg_done), 64'(0));
    check("early_ready", 64'(cfg_ready), 64'(1));
    load_words(8, 8'hFF, "finish");
    check("full_loaded2", 64'(cfg_loaded), 64'(1));
    check("full_not_ready", 64'(cfg_ready), 64'(0));
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'h00, 1'b0, rnd_s(), "extra_valid");
    commit_apply("commitFF");
    S_END = rnd_s() | 52'h1;
    #1;
    check("tie_low_all", 64'(N_BEG), 64'(0));

    // Reset mid-load.
    load_words(7, 8'hAA, "midload");
    resetn = 1'b0;
    S_END  = 52'h1;
    #2;
    m_reset();
    check("rst_ready", 64'(cfg_ready), 64'(1));
    check("rst_loaded", 64'(cfg_loaded), 64'(0));
    check("rst_done", 64'(cfg_done), 64'(0));
    check("rst_mirror", 64'(N_BEG), 64'(52'h8_0000_0000_0000));
    @(posedge UserCLK);
    #1;
    resetn = 1'b1;
    load_words(NW - 1, 8'hAA, "after_rst");
    check("count_cleared", 64'(cfg_loaded), 64'(0));

    // Last word 0xFF ties the top four channels low.
    cycle(1'b1, 8'hFF, 1'b0, rnd_s(), "last_ff");
    commit_apply("commit_last");
    for (int k = 0; k < 3; k++) begin
      S_END = rnd_s();
      #1;
      check($sformatf("top_tie[%0d]", k), 64'(N_BEG[51:48]), 64'(0));
      check($sformatf("low_straight[%0d]", k), 64'(N_BEG[47:0]), 64'(S_END[47:0]));
    end

    // Randomized run against the model.
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 2) != 0), 8'($urandom()), ($urandom_range(0, 7) == 0),
            rnd_s(), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
